condicionador_botoes: RTL and testbench

CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

---
 rtl/condicionador_botoes.sv | 118 +++++++++++
 tb/tb_condicionador_botoes.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/condicionador_botoes.sv
// Button conditioner for a 3x3 board: synchronizes, debounces and rejects multi-press,
// emitting a single one-cycle move pulse per debounced press/release cycle.
module condicionador_botoes #(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] botoes,
  input  logic       habilitar,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       erro_multiplo,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    FILTRANDO     = 2'd1,
    EMITE         = 2'd2,
    ESPERA_SOLTAR = 2'd3
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [8:0]    sinc1_q, sinc_q;
  logic [8:0]    cap_q, cap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    jogada_q, jogada_d;
  logic          tem_q, tem_d;
  logic          erro_q, erro_d;

  function automatic logic um_bit(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

  function automatic logic [3:0] indice(input logic [8:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 9; i++)
      if (v[i]) r = 4'(i);
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      sinc1_q  <= '0;
      sinc_q   <= '0;
      estado_q <= OCIOSO;
      cap_q    <= '0;
      cnt_q    <= '0;
      jogada_q <= '0;
      tem_q    <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      sinc1_q  <= botoes;
      sinc_q   <= sinc1_q;
      estado_q <= estado_d;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      jogada_q <= jogada_d;
      tem_q    <= tem_d;
      erro_q   <= erro_d;
    end
  end

  // Counter is compared against CNT_MAX before incrementing, so it never wraps.
  always_comb begin
    estado_d = estado_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    jogada_d = jogada_q;
    tem_d    = 1'b0;
    erro_d   = erro_q;
    case (estado_q)
      OCIOSO: begin
        if (habilitar && (sinc_q != 9'd0)) begin
          cnt_d = '0;
          if (um_bit(sinc_q)) begin
            estado_d = FILTRANDO;
            cap_d    = sinc_q;
          end else begin
            estado_d = ESPERA_SOLTAR;
            erro_d   = 1'b1;
          end
        end
      end
      FILTRANDO: begin
        if ((sinc_q != cap_q) || !habilitar) estado_d = OCIOSO;
        else if (cnt_q == CNT_MAX)           estado_d = EMITE;
        else                                 cnt_d = cnt_q + CW'(1);
      end
      EMITE: begin
        tem_d    = 1'b1;
        jogada_d = indice(cap_q);
        estado_d = ESPERA_SOLTAR;
        cnt_d    = '0;
      end
      ESPERA_SOLTAR: begin
        if (sinc_q != 9'd0) cnt_d = '0;
        else if (cnt_q == CNT_MAX) begin
          estado_d = OCIOSO;
          erro_d   = 1'b0;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign jogada        = jogada_q;
  assign tem_jogada    = tem_q;
  assign erro_multiplo = erro_q;
  assign ocupado       = (estado_q != OCIOSO);
  assign db_estado     = {2'b00, estado_q};

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: directed scenarios plus randomized button traffic
// checked cycle by cycle against a timestamp-based reference model.
module tb_condicionador_botoes;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset, habilitar;
  logic [8:0] botoes;
  logic [3:0] jogada, db_estado;
  logic       tem_jogada, erro_multiplo, ocupado;

  always #5 clock = ~clock;

  condicionador_botoes #(.DEBOUNCE_CICLOS(D)) dut (
    .clock(clock), .reset(reset), .botoes(botoes), .habilitar(habilitar),
    .jogada(jogada), .tem_jogada(tem_jogada), .erro_multiplo(erro_multiplo),
    .ocupado(ocupado), .db_estado(db_estado)
  );

  int n_tests = 0, n_fail = 0;
  int edge_n = 0, pulses = 0, last_pulse = -1;

  // reference model: raw history, phase code and the edge where the current timing window started
  logic [8:0] raw_hist[$];
  int         m_st = 0, t_mark = 0;
  logic [8:0] m_cap = '0;
  logic [3:0] m_jog = '0;
  logic       m_tj = 1'b0, m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic logic [3:0] pos_of(input logic [8:0] v);
    for (int i = 0; i < 9; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  // sinc seen by the FSM at this edge is the raw value applied two edges earlier
  task automatic model_edge(input logic r, input logic h, input logic [8:0] b);
    logic [8:0] s;
    s = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 9'd0;
    if (r) begin
      m_st = 0; m_cap = '0; m_jog = '0; m_tj = 1'b0; m_err = 1'b0;
      raw_hist.delete();
      raw_hist.push_back(9'd0);
      raw_hist.push_back(9'd0);
    end else begin
      m_tj = 1'b0;
      case (m_st)
        0: if (h && s != 0) begin
             t_mark = edge_n;
             if ($countones(s) == 1) begin m_st = 1; m_cap = s; end
             else begin m_st = 3; m_err = 1'b1; end
           end
        1: if (s != m_cap || !h) m_st = 0;
           else if (edge_n - t_mark == D) m_st = 2;
        2: begin m_tj = 1'b1; m_jog = pos_of(m_cap); m_st = 3; t_mark = edge_n; end
        default: if (s != 0) t_mark = edge_n;
                 else if (edge_n - t_mark == D) begin m_st = 0; m_err = 1'b0; end
      endcase
      raw_hist.push_back(b);
      if (raw_hist.size() > 2) void'(raw_hist.pop_front());
    end
  endtask

  task automatic step(input logic r, input logic h, input logic [8:0] b);
    reset = r; habilitar = h; botoes = b;
    @(posedge clock);
    edge_n++;
    model_edge(r, h, b);
    #1;
    check("tem_jogada", 32'(tem_jogada), 32'(m_tj));
    check("jogada", 32'(jogada), 32'(m_jog));
    check("erro_multiplo", 32'(erro_multiplo), 32'(m_err));
    check("db_estado", 32'(db_estado), 32'(m_st));
    check("ocupado", 32'(ocupado), 32'(m_st != 0));
    if (tem_jogada) begin pulses++; last_pulse = edge_n; end
  endtask

  task automatic soltar(input int n);
    repeat (n) step(1'b0, 1'b1, 9'd0);
  endtask

  int p0, k0;

  initial begin
    reset = 1'b1; habilitar = 1'b0; botoes = '0;
    repeat (2) step(1'b1, 1'b0, 9'd0);
    check("reset_db", 32'(db_estado), 0);
    check("reset_jog", 32'(jogada), 0);

    // single button held
    p0 = pulses; k0 = edge_n + 1;
    repeat (20) step(1'b0, 1'b1, 9'h010);
    check("held_count", 32'(pulses - p0), 1);
    check("held_latency", 32'(last_pulse - k0), 7);
    check("held_jog", 32'(jogada), 4);
    soltar(8);

    // bouncing press: 2 on, 1 off, then held
    p0 = pulses;
    repeat (2) step(1'b0, 1'b1, 9'h001);
    step(1'b0, 1'b1, 9'h000);
    k0 = edge_n + 1;
    repeat (15) step(1'b0, 1'b1, 9'h001);
    check("bounce_count", 32'(pulses - p0), 1);
    check("bounce_latency", 32'(last_pulse - k0), 7);
    check("bounce_jog", 32'(jogada), 0);
    soltar(8);

    // two buttons together
    p0 = pulses;
    repeat (6) step(1'b0, 1'b1, 9'h003);
    check("multi_err", 32'(erro_multiplo), 1);
    check("multi_db", 32'(db_estado), 3);
    check("multi_nopulse", 32'(pulses - p0), 0);
    soltar(6);
    check("multi_err_clear", 32'(erro_multiplo), 0);
    check("multi_db_clear", 32'(db_estado), 0);

    // disabled, then enabled with button already stable
    p0 = pulses;
    repeat (10) step(1'b0, 1'b0, 9'h100);
    check("dis_nopulse", 32'(pulses - p0), 0);
    check("dis_db", 32'(db_estado), 0);
    k0 = edge_n + 1;
    repeat (10) step(1'b0, 1'b1, 9'h100);
    check("en_count", 32'(pulses - p0), 1);
    check("en_latency", 32'(last_pulse - k0), 5);
    check("en_jog", 32'(jogada), 8);
    soltar(8);

    // reset mid-debounce, button kept held
    p0 = pulses;
    repeat (4) step(1'b0, 1'b1, 9'h040);
    check("pre_rst_db", 32'(db_estado), 1);
    step(1'b1, 1'b1, 9'h040);
    check("rst_db", 32'(db_estado), 0);
    check("rst_jog", 32'(jogada), 0);
    check("rst_tj", 32'(tem_jogada), 0);
    k0 = edge_n + 1;
    repeat (12) step(1'b0, 1'b1, 9'h040);
    check("rst_count", 32'(pulses - p0), 1);
    check("rst_latency", 32'(last_pulse - k0), 7);
    check("rst_jog_after", 32'(jogada), 6);
    soltar(8);

    // short release followed by another press is ignored
    p0 = pulses;
    repeat (12) step(1'b0, 1'b1, 9'h010);
    soltar(2);
    repeat (10) step(1'b0, 1'b1, 9'h020);
    check("ignored_count", 32'(pulses - p0), 1);
    check("ignored_jog", 32'(jogada), 4);
    soltar(8);
    repeat (12) step(1'b0, 1'b1, 9'h020);
    check("clean_count", 32'(pulses - p0), 2);
    check("clean_jog", 32'(jogada), 5);
    soltar(8);

    // randomized traffic
    for (int seg = 0; seg < 400; seg++) begin
      logic [8:0] b;
      logic       h, r;
      int         len, kind;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2:    b = 9'd0;
        3, 4, 5, 6: b = 9'(1) << $urandom_range(0, 8);
        7:          b = 9'($urandom_range(0, 511));
        default:    b = (9'(1) << $urandom_range(0, 8)) | (9'(1) << $urandom_range(0, 8));
      endcase
      h   = ($urandom_range(0, 7) != 0);
      r   = ($urandom_range(0, 40) == 0);
      len = $urandom_range(1, 10);
      if (r) step(1'b1, h, b);
      repeat (len) step(1'b0, h, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
